// File: rtl/secuenciador_desplazamiento.sv
// Multi-pass controller around the external 4-bit left shifter: splits a shift of up to
// 2^CNT_W-1 positions into passes of at most 3, with start/busy/done handshake and sticky overflow.
module secuenciador_desplazamiento #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dato_in,
    input  logic [CNT_W-1:0] cantidad,
    output logic             ocupado,
    output logic             listo,
    output logic [WIDTH-1:0] dato_out,
    output logic             desb,
    output logic [WIDTH-1:0] sh_A,
    output logic [1:0]       sh_B,
    input  logic [WIDTH-1:0] sh_E
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] val_r;
    logic [CNT_W-1:0] rem_r;
    logic             sticky_r;
    logic [WIDTH-1:0] dato_out_r;
    logic             desb_r;
    logic             listo_r;
    logic             ocupado_r;

    logic [1:0]       paso_s;
    logic [WIDTH-1:0] sh_a_s;
    logic [CNT_W-1:0] rem_next_s;
    logic             perdido_s;
    logic             perdido_acum_s;

    // OR of the top n bits of v: the bits a left shift by n pushes out of the word.
    function automatic logic bits_perdidos(input logic [WIDTH-1:0] v, input logic [1:0] n);
        logic [WIDTH-1:0] mascara;
        mascara = ~({WIDTH{1'b1}} >> n);
        return |(v & mascara);
    endfunction

    // Pass size and shifter drive; the shifter sees zeros outside SHIFT.
    always_comb begin
        paso_s = 2'd0;
        sh_a_s = {WIDTH{1'b0}};
        if (state_r == SHIFT) begin
            sh_a_s = val_r;
            if (rem_r >= CNT_W'(2'd3)) begin
                paso_s = 2'd3;
            end else begin
                paso_s = rem_r[1:0];
            end
        end else begin
            paso_s = 2'd0;
            sh_a_s = {WIDTH{1'b0}};
        end
    end

    // Next remaining count and overflow accumulation for the current pass.
    always_comb begin
        rem_next_s     = rem_r - CNT_W'(paso_s);
        perdido_s      = bits_perdidos(val_r, paso_s);
        perdido_acum_s = sticky_r | perdido_s;
    end

    assign sh_A     = sh_a_s;
    assign sh_B     = paso_s;
    assign ocupado  = ocupado_r;
    assign listo    = listo_r;
    assign dato_out = dato_out_r;
    assign desb     = desb_r;

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            val_r      <= {WIDTH{1'b0}};
            rem_r      <= {CNT_W{1'b0}};
            sticky_r   <= 1'b0;
            dato_out_r <= {WIDTH{1'b0}};
            desb_r     <= 1'b0;
            listo_r    <= 1'b0;
            ocupado_r  <= 1'b0;
        end else begin
            listo_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        val_r     <= dato_in;
                        rem_r     <= cantidad;
                        sticky_r  <= 1'b0;
                        ocupado_r <= 1'b1;
                        if (cantidad != {CNT_W{1'b0}}) begin
                            state_r <= SHIFT;
                        end else begin
                            // Zero shift: result is the operand itself, nothing lost.
                            state_r    <= DONE;
                            dato_out_r <= dato_in;
                            desb_r     <= 1'b0;
                            listo_r    <= 1'b1;
                        end
                    end else begin
                        state_r   <= IDLE;
                        ocupado_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    val_r    <= sh_E;
                    rem_r    <= rem_next_s;
                    sticky_r <= perdido_acum_s;
                    if (rem_next_s == {CNT_W{1'b0}}) begin
                        state_r    <= DONE;
                        dato_out_r <= sh_E;
                        desb_r     <= perdido_acum_s;
                        listo_r    <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    ocupado_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    ocupado_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_desplazamiento.sv
// Scoreboard bench for secuenciador_desplazamiento: a timing model pushes expected results on
// each accepted start; a negedge monitor checks handshake, shifter drive and results.
module tb_secuenciador_desplazamiento;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dato_in = 4'd0;
    logic [2:0] cantidad = 3'd0;
    logic       ocupado;
    logic       listo;
    logic [3:0] dato_out;
    logic       desb;
    logic [3:0] sh_A;
    logic [1:0] sh_B;
    logic [3:0] sh_E;

    secuenciador_desplazamiento #(.WIDTH(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dato_in  (dato_in),
        .cantidad (cantidad),
        .ocupado  (ocupado),
        .listo    (listo),
        .dato_out (dato_out),
        .desb     (desb),
        .sh_A     (sh_A),
        .sh_B     (sh_B),
        .sh_E     (sh_E)
    );

    // Behavioural stand-in for the external combinational shifter.
    assign sh_E = sh_A << sh_B;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic       o;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mdl_left = 0;
    int   mdl_rem = 0;
    logic hand_valid = 1'b0;
    exp_t hand_exp = '0;
    exp_t held = '0;
    exp_t popped;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_op(input logic [3:0] d, input logic [2:0] c);
        logic [3:0] m;
        exp_t r;
        m = 4'hF >> c;
        r.d = d << c;
        r.o = |(d & ~m);
        return r;
    endfunction

    // Reference timing model: busy for ceil(c/3) shift cycles plus one done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_left <= 0;
            mdl_rem  <= 0;
            sb_q.delete();
        end else if (mdl_left > 0) begin
            if (mdl_rem > 0) mdl_rem <= mdl_rem - ((mdl_rem >= 3) ? 3 : mdl_rem);
            mdl_left <= mdl_left - 1;
        end else if (start) begin
            sb_q.push_back(hand_valid ? hand_exp : ref_op(dato_in, cantidad));
            mdl_rem  <= int'(cantidad);
            mdl_left <= (int'(cantidad) + 2) / 3 + 1;
        end
    end

    // Monitor: handshake timing, shifter drive and held results every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = '0;
        end else begin
            chk("ocupado", 32'(ocupado), 32'(mdl_left > 0));
            chk("listo", 32'(listo), 32'(mdl_left == 1));
            chk("sh_B", 32'(sh_B), (mdl_left > 0 && mdl_rem > 0) ? ((mdl_rem >= 3) ? 32'd3 : 32'(mdl_rem)) : 32'd0);
            if (listo) begin
                if (sb_q.size() == 0) begin
                    chk("listo_unexpected", 32'd1, 32'd0);
                end else begin
                    popped = sb_q.pop_front();
                    held = popped;
                end
            end
            chk("dato_out", 32'(dato_out), 32'(held.d));
            chk("desb", 32'(desb), 32'(held.o));
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (mdl_left != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (mdl_left != 0) chk("timeout_idle", 32'(mdl_left), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] d, input logic [2:0] c, input logic hv,
                          input logic [3:0] ho, input logic hd, input logic busy_pulse);
        wait_idle();
        #1;
        start = 1'b1;
        dato_in = d;
        cantidad = c;
        hand_valid = hv;
        hand_exp = '{d: ho, o: hd};
        @(negedge clk);
        #1;
        hand_valid = 1'b0;
        dato_in = ~d;
        cantidad = c + 3'd1;
        start = busy_pulse;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        chk("rst_dato_out", 32'(dato_out), 32'd0);
        chk("rst_desb", 32'(desb), 32'd0);
        #1 rst_n = 1'b1;

        // Directed cases with hand-computed results.
        run_op(4'b1010, 3'd0, 1'b1, 4'b1010, 1'b0, 1'b0);
        run_op(4'b0001, 3'd3, 1'b1, 4'b1000, 1'b0, 1'b0);
        run_op(4'b0011, 3'd5, 1'b1, 4'b0000, 1'b1, 1'b0);
        run_op(4'b0110, 3'd1, 1'b1, 4'b1100, 1'b0, 1'b1);
        run_op(4'b1001, 3'd2, 1'b1, 4'b0100, 1'b1, 1'b1);

        // Reset in the second shift cycle of a 7-position shift.
        wait_idle();
        #1;
        start = 1'b1;
        dato_in = 4'b1111;
        cantidad = 3'd7;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ocupado", 32'(ocupado), 32'd0);
        chk("midrst_listo", 32'(listo), 32'd0);
        chk("midrst_dato_out", 32'(dato_out), 32'd0);
        chk("midrst_desb", 32'(desb), 32'd0);
        chk("midrst_sh_A", 32'(sh_A), 32'd0);
        chk("midrst_sh_B", 32'(sh_B), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_op(4'b0101, 3'd4, 1'b1, 4'b0000, 1'b1, 1'b0);

        // Exhaustive operand/amount sweep, alternating starts while busy.
        for (int d = 0; d < 16; d++) begin
            for (int c = 0; c < 8; c++) begin
                run_op(4'(d), 3'(c), 1'b0, 4'd0, 1'b0, 1'((d + c) % 2));
            end
        end

        // Back-to-back: start held high, operand changes every cycle.
        wait_idle();
        #1;
        start = 1'b1;
        cantidad = 3'd1;
        for (int i = 0; i < 12; i++) begin
            dato_in = 4'(i * 5 + 3);
            @(negedge clk);
            #1;
        end
        start = 1'b0;

        wait_idle();
        @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
